// File: rtl/skid_buffer_ctrl.sv
// Two-entry skid buffer: registered in_ready/out_valid, strict FIFO order, no bubbles.
// Optional stall counter output enabled by defining SKID_BUFFER_STALL_CNT_EN.
module skid_buffer_ctrl #(
  parameter int                 WIDTH       = 32,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
  parameter int                 CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 out_ready,
`ifdef SKID_BUFFER_STALL_CNT_EN
  output logic [CNT_WIDTH-1:0] stall_count,
`endif
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             load_main;
  logic             load_skid;
  logic             main_from_skid;

  // Handshake: a transfer happens on a rising edge where valid && ready on that side.
  // in_ready and out_valid are pure decodes of the state register, so neither
  // depends combinationally on the opposite side's handshake inputs.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state     = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (in_valid) begin
          load_main  = 1'b1;
          next_state = BUSY;
        end
      end
      BUSY: begin
        if (in_valid && out_ready) begin
          load_main = 1'b1;
        end else if (in_valid) begin
          load_skid  = 1'b1;
          next_state = FULL;
        end else if (out_ready) begin
          next_state = EMPTY;
        end
      end
      FULL: begin
        if (out_ready) begin
          load_main      = 1'b1;
          main_from_skid = 1'b1;
          next_state     = BUSY;
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= RESET_VALUE;
      skid_q <= RESET_VALUE;
    end else begin
      if (load_main) begin
        main_q <= main_from_skid ? skid_q : in_data;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

`ifdef SKID_BUFFER_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (out_valid && !out_ready && (stall_count != {CNT_WIDTH{1'b1}})) begin
      stall_count <= stall_count + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_skid_buffer_ctrl.sv
// Self-checking bench for skid_buffer_ctrl: directed scenarios plus a queue scoreboard
// that tracks every input transfer and checks every output transfer in order.
module tb_skid_buffer_ctrl;

  localparam int W  = 4;
  localparam int CW = 16;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic [1:0]    state_dbg;
`ifdef SKID_BUFFER_STALL_CNT_EN
  logic [CW-1:0] stall_count;
`endif

  int tests_run;
  int tests_failed;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;

  skid_buffer_ctrl #(.WIDTH(W), .RESET_VALUE('0), .CNT_WIDTH(CW)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
`ifdef SKID_BUFFER_STALL_CNT_EN
    .stall_count(stall_count),
`endif
    .state_dbg(state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: samples on the falling edge what the next rising edge will transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_underflow: got %h with nothing expected", out_data);
        end else begin
          exp_v = exp_q.pop_front();
          if (out_data !== exp_v) begin
            tests_failed++;
            $display("FAIL sb_order: got %h expected %h", out_data, exp_v);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  // Driver: apply inputs, advance one rising edge, settle 1 time unit after it.
  task automatic drive(input logic v, input logic [W-1:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #3;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_values: in_ready=%b out_valid=%b out_data=%h expected 1 0 0", in_ready, out_valid, out_data);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) drive(1'b0, 4'h0, 1'b0);
    tests_run++;
    if (state_dbg !== 2'b00 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_hold: state=%b out_valid=%b in_ready=%b expected 00 0 1", state_dbg, out_valid, in_ready);
    end
  endtask

  task automatic test_streaming;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, W'(i), 1'b1);
      tests_run++;
      if (out_data !== W'(i) || out_valid !== 1'b1 || in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL stream_%0d: out_data=%h out_valid=%b in_ready=%b expected %h 1 1", i, out_data, out_valid, in_ready, W'(i));
      end
    end
    drive(1'b0, 4'h0, 1'b1);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stream_end: out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_backpressure;
    drive(1'b1, 4'h3, 1'b0);
    drive(1'b1, 4'h5, 1'b0);
    tests_run++;
    if (out_data !== 4'h3 || in_ready !== 1'b0 || out_valid !== 1'b1 || state_dbg !== 2'b10) begin
      tests_failed++;
      $display("FAIL bp_full: out_data=%h in_ready=%b out_valid=%b state=%b expected 3 0 1 10", out_data, in_ready, out_valid, state_dbg);
    end
    drive(1'b1, 4'h9, 1'b0);
    drive(1'b1, 4'h9, 1'b0);
    tests_run++;
    if (out_data !== 4'h3 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_hold: out_data=%h in_ready=%b expected 3 0", out_data, in_ready);
    end
    drive(1'b0, 4'h0, 1'b1);
    tests_run++;
    if (out_data !== 4'h5 || in_ready !== 1'b1 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_release: out_data=%h in_ready=%b out_valid=%b expected 5 1 1", out_data, in_ready, out_valid);
    end
    drive(1'b0, 4'h0, 1'b1);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_empty: out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_drain;
    drive(1'b1, 4'hA, 1'b1);
    drive(1'b0, 4'h0, 1'b1);
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== 4'hA || state_dbg !== 2'b00) begin
      tests_failed++;
      $display("FAIL drain: out_valid=%b out_data=%h state=%b expected 0 a 00", out_valid, out_data, state_dbg);
    end
    drive(1'b0, 4'h0, 1'b0);
    drive(1'b0, 4'h0, 1'b1);
    tests_run++;
    if (state_dbg !== 2'b00 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL empty_idle: state=%b out_valid=%b expected 00 0", state_dbg, out_valid);
    end
  endtask

  task automatic test_reset_full;
    drive(1'b1, 4'h1, 1'b0);
    drive(1'b1, 4'h2, 1'b0);
    tests_run++;
    if (state_dbg !== 2'b10) begin
      tests_failed++;
      $display("FAIL rf_fill: state=%b expected 10", state_dbg);
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 4'h0) begin
      tests_failed++;
      $display("FAIL rf_async: out_valid=%b in_ready=%b out_data=%h expected 0 1 0", out_valid, in_ready, out_data);
    end
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1'b1, 4'h7, 1'b1);
    tests_run++;
    if (out_data !== 4'h7 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rf_next: out_data=%h out_valid=%b expected 7 1", out_data, out_valid);
    end
    drive(1'b0, 4'h0, 1'b1);
  endtask

  task automatic test_random;
    int budget;
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), W'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
    end
    budget = 0;
    in_valid = 1'b0;
    while ((out_valid || exp_q.size() != 0) && budget < 10) begin
      drive(1'b0, 4'h0, 1'b1);
      budget++;
    end
    tests_run++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL random_drain: left=%0d out_valid=%b expected 0 0", exp_q.size(), out_valid);
    end
  endtask

`ifdef SKID_BUFFER_STALL_CNT_EN
  task automatic test_stall_count;
    #2 rst = 1'b1;
    #1 exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    tests_run++;
    if (stall_count !== '0) begin
      tests_failed++;
      $display("FAIL stall_reset: stall_count=%0d expected 0", stall_count);
    end
    drive(1'b1, 4'h9, 1'b0);
    repeat (10) drive(1'b0, 4'h0, 1'b0);
    tests_run++;
    if (stall_count !== CW'(10)) begin
      tests_failed++;
      $display("FAIL stall_count: stall_count=%0d expected 10", stall_count);
    end
    drive(1'b0, 4'h0, 1'b1);
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_drain();
    test_reset_full();
    test_random();
`ifdef SKID_BUFFER_STALL_CNT_EN
    test_stall_count();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
